iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; legal values 16, 32, 64.
REQ-002 Parameter CNT_W, default $clog2(XLEN)+1, iteration counter width; derived, not overridden.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 i_PC  input  XLEN  PC of the issuing instruction.
REQ-006 i_Op_5  input  5  operation code: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 LUI (pass op2), 11 PC4, 12 MUL, 13 MULH, 14 MULHSU, 15 MULHU, 16 DIV, 17 DIVU, 18 REM, 19 REMU; 20-31 reserved.
REQ-007 i_Operand1  input  XLEN  first operand (rs1/PC).
REQ-008 i_Operand2  input  XLEN  second operand (rs2/imm).
REQ-009 i_Valid  input  1  request valid.
REQ-010 o_Ready  output  1  block can accept a request.
REQ-011 i_Flush  input  1  synchronous abort of any in-flight operation.
REQ-012 o_Valid  output  1  o_Result holds a completed result.
REQ-013 i_Ready  input  1  consumer takes result.
REQ-014 o_Result  output  XLEN  registered result.
REQ-015 o_Busy  output  1  high while in BUSY state.
REQ-016 o_JumpBranchAddr  output  XLEN  combinational i_Operand1+i_Operand2, modulo 2^XLEN.
REQ-017 o_PCPlus4  output  XLEN  combinational i_PC+4, modulo 2^XLEN.

Function
REQ-018 Accept occurs on a rising edge with i_Valid && o_Ready && !i_Flush; operands and op are captured internally at accept.
REQ-019 States: IDLE, BUSY, DONE; o_Ready = (IDLE) || (DONE && i_Ready).
REQ-020 Ops 0-11 and reserved ops: accept goes to DONE, o_Valid high the next cycle (latency 1); reserved ops yield 0.
REQ-021 Ops 0-11 semantics: RV32I-equivalent at XLEN width; shifts use operand2[log2(XLEN)-1:0]; SLT signed, SLTU unsigned, result 1 or 0 zero-extended.
REQ-022 Ops 12-19 go to BUSY, counter loaded with XLEN, one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes), counter decrements; at counter 1 next state DONE; o_Valid high XLEN+1 cycles after accept.
REQ-023 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of the 2*XLEN product with ss/su/uu signedness.
REQ-024 DIV/REM truncate toward zero; remainder sign follows dividend.
REQ-025 Divide by zero: quotient all-ones, remainder = dividend, bypasses BUSY, latency 1.
REQ-026 Signed overflow (dividend = -2^(XLEN-1), divisor = -1): DIV returns dividend, REM returns 0, latency 1.
REQ-027 DONE holds o_Valid and o_Result stable until i_Ready; on i_Ready without new accept return to IDLE; with simultaneous accept, follow REQ-020/022 (back-to-back, no bubble).
REQ-028 Operand inputs changing during BUSY have no effect on the result.
REQ-029 i_Flush: next edge forces IDLE, o_Valid 0, o_Result unchanged; flush wins over simultaneous accept and completion.
REQ-030 o_JumpBranchAddr and o_PCPlus4 are independent of state and handshake.

Reset
REQ-031 rst_n low asynchronously forces IDLE, o_Valid 0, o_Busy 0, o_Result 0, counter 0, internal operand registers 0.
REQ-032 Reset asserted mid-BUSY discards the operation; after deassertion o_Ready is 1 on the first edge and no stale o_Valid appears.

Verification
REQ-033 XLEN=32, ADD 0x7FFFFFFF+1, i_Ready=1 -> o_Valid one cycle after accept, o_Result 0x80000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-034 MULH 0x80000000*0x80000000 -> o_Valid exactly 33 cycles after accept, o_Result 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF at latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at latency 1.
REQ-036 i_Ready held 0 for 5 cycles after completion -> o_Valid and o_Result stable, o_Ready 0; then i_Ready=1 with new ADD on i_Valid -> accepted same edge, next result one cycle later.
REQ-037 i_Flush pulsed at cycle 10 of a DIVU -> IDLE next edge, o_Valid never asserted for that DIVU; rst_n pulsed low mid-MUL -> o_Result 0, o_Valid 0 immediately.
REQ-038 XLEN=64 rerun of REQ-034 with 64-bit operands -> latency 65, results match a 128-bit reference model.

Source files
------------

// File: rtl/iter_alu.sv
// Iterative ALU: ops 0-11, reserved ops and div special cases finish in 1 cycle; mul/div take XLEN+1 cycles.
// The result is held in DONE until i_Ready; o_Ready is high only when IDLE or when the held result drains this edge.
`timescale 1ns/1ps
module iter_alu #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] i_PC,
   input  logic [4:0]      i_Op_5,
   input  logic [XLEN-1:0] i_Operand1,
   input  logic [XLEN-1:0] i_Operand2,
   input  logic            i_Valid,
   output logic            o_Ready,
   input  logic            i_Flush,
   output logic            o_Valid,
   input  logic            i_Ready,
   output logic [XLEN-1:0] o_Result,
   output logic            o_Busy,
   output logic [XLEN-1:0] o_JumpBranchAddr,
   output logic [XLEN-1:0] o_PCPlus4
);
   localparam int SH_W = $clog2(XLEN);

   localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB    = 5'd1,  OP_SLT   = 5'd2,  OP_SLTU  = 5'd3;
   localparam logic [4:0] OP_AND  = 5'd4,  OP_OR     = 5'd5,  OP_XOR   = 5'd6,  OP_SLL   = 5'd7;
   localparam logic [4:0] OP_SRL  = 5'd8,  OP_SRA    = 5'd9,  OP_LUI   = 5'd10, OP_PC4   = 5'd11;
   localparam logic [4:0] OP_MUL  = 5'd12, OP_MULH   = 5'd13, OP_MULHSU = 5'd14, OP_MULHU = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16, OP_DIVU   = 5'd17, OP_REM   = 5'd18, OP_REMU  = 5'd19;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [4:0]          op_q, op_d;
   logic [XLEN-1:0]     mcand_q, mcand_d;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic                neg_q, neg_d, negr_q, negr_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                accept, is_mul, is_div, div_zero, div_ovf, is_iter;
   logic                sgn1, sgn2, neg1, neg2;
   logic [XLEN-1:0]     mag1, mag2, fast_res, iter_res, q_fin, r_fin;
   logic [SH_W-1:0]     shamt;
   logic [XLEN:0]       mul_sum, div_rs, div_diff;
   logic [2*XLEN-1:0]   step, full;

   assign o_JumpBranchAddr = i_Operand1 + i_Operand2;
   assign o_PCPlus4        = i_PC + XLEN'(4);
   assign o_Result         = result_q;
   assign accept           = i_Valid && o_Ready && !i_Flush;

   // Request decode: operand signedness, magnitudes and divide special cases
   always_comb begin
      is_mul   = (i_Op_5 >= OP_MUL) && (i_Op_5 <= OP_MULHU);
      is_div   = (i_Op_5 >= OP_DIV) && (i_Op_5 <= OP_REMU);
      sgn1     = (i_Op_5 == OP_MULH) || (i_Op_5 == OP_MULHSU) || (i_Op_5 == OP_DIV) || (i_Op_5 == OP_REM);
      sgn2     = (i_Op_5 == OP_MULH) || (i_Op_5 == OP_DIV) || (i_Op_5 == OP_REM);
      neg1     = sgn1 && i_Operand1[XLEN-1];
      neg2     = sgn2 && i_Operand2[XLEN-1];
      mag1     = neg1 ? -i_Operand1 : i_Operand1;
      mag2     = neg2 ? -i_Operand2 : i_Operand2;
      div_zero = is_div && (i_Operand2 == '0);
      div_ovf  = is_div && sgn1 && (i_Operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_Operand2 == '1);
      is_iter  = is_mul || (is_div && !div_zero && !div_ovf);
   end

   always_comb begin
      shamt    = i_Operand2[SH_W-1:0];
      fast_res = '0;
      case (i_Op_5)
         OP_ADD:            fast_res = i_Operand1 + i_Operand2;
         OP_SUB:            fast_res = i_Operand1 - i_Operand2;
         OP_SLT:            fast_res = {{(XLEN-1){1'b0}}, $signed(i_Operand1) < $signed(i_Operand2)};
         OP_SLTU:           fast_res = {{(XLEN-1){1'b0}}, i_Operand1 < i_Operand2};
         OP_AND:            fast_res = i_Operand1 & i_Operand2;
         OP_OR:             fast_res = i_Operand1 | i_Operand2;
         OP_XOR:            fast_res = i_Operand1 ^ i_Operand2;
         OP_SLL:            fast_res = i_Operand1 << shamt;
         OP_SRL:            fast_res = i_Operand1 >> shamt;
         OP_SRA:            fast_res = $signed(i_Operand1) >>> shamt;
         OP_LUI:            fast_res = i_Operand2;
         OP_PC4:            fast_res = i_PC + XLEN'(4);
         // Only reached for divide-by-zero or signed overflow; other divides iterate
         OP_DIV, OP_DIVU:   fast_res = div_zero ? '1 : i_Operand1;
         OP_REM, OP_REMU:   fast_res = div_zero ? i_Operand1 : '0;
         default:           fast_res = '0;
      endcase
   end

   // One radix-2 step on magnitudes; prod_q is {acc, multiplier} or {remainder, quotient}
   always_comb begin
      mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      div_rs   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
      div_diff = div_rs - {1'b0, mcand_q};
      if (op_q[4]) begin
         if (div_diff[XLEN]) step = {div_rs[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
         else                step = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
      end else begin
         step = {mul_sum, prod_q[XLEN-1:1]};
      end
      full  = neg_q ? -step : step;
      q_fin = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
      r_fin = negr_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                       iter_res = full[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: iter_res = full[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              iter_res = q_fin;
         default:                      iter_res = r_fin;
      endcase
   end

   always_comb begin
      op_d     = op_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      neg_d    = neg_q;
      negr_d   = negr_q;
      result_d = result_q;
      if (accept) begin
         op_d    = i_Op_5;
         cnt_d   = is_iter ? CNT_W'(XLEN) : '0;
         neg_d   = neg1 ^ neg2;
         negr_d  = neg1;
         mcand_d = is_div ? mag2 : mag1;
         prod_d  = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
         if (!is_iter) result_d = fast_res;
      end else if (state_q == S_BUSY && !i_Flush) begin
         prod_d = step;
         cnt_d  = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) result_d = iter_res;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         neg_q    <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
      end else begin
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         neg_q    <= neg_d;
         negr_q   <= negr_d;
         result_q <= result_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (i_Flush) begin
         state_d = S_IDLE;
      end else if (accept) begin
         state_d = is_iter ? S_BUSY : S_DONE;
      end else begin
         case (state_q)
            S_BUSY:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  if (i_Ready) state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      o_Valid = (state_q == S_DONE);
      o_Busy  = (state_q == S_BUSY);
      o_Ready = (state_q == S_IDLE) || ((state_q == S_DONE) && i_Ready);
   end
endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: a 32-bit instance for function/handshake, a 64-bit instance for wide multiply.
`timescale 1ns/1ps
module tb_iter_alu;
   localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLT = 5'd2, OP_SLTU = 5'd3, OP_AND = 5'd4;
   localparam logic [4:0] OP_OR = 5'd5, OP_XOR = 5'd6, OP_SLL = 5'd7, OP_SRL = 5'd8, OP_SRA = 5'd9;
   localparam logic [4:0] OP_LUI = 5'd10, OP_PC4 = 5'd11, OP_MUL = 5'd12, OP_MULH = 5'd13;
   localparam logic [4:0] OP_MULHSU = 5'd14, OP_MULHU = 5'd15, OP_DIV = 5'd16, OP_DIVU = 5'd17;
   localparam logic [4:0] OP_REM = 5'd18, OP_REMU = 5'd19, OP_RSVD = 5'd25;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc, a, b, res, jba, pc4;
   logic [4:0]  op;
   logic        vld, rdy_in, flush, o_rdy, o_vld, o_busy;

   logic [63:0] pc64, a64, b64, res64, jba64, pc464;
   logic [4:0]  op64;
   logic        vld64, rdy64, o_rdy64, o_vld64, o_busy64;

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   iter_alu dut (
      .clk(clk), .rst_n(rst_n), .i_PC(pc), .i_Op_5(op), .i_Operand1(a), .i_Operand2(b),
      .i_Valid(vld), .o_Ready(o_rdy), .i_Flush(flush), .o_Valid(o_vld), .i_Ready(rdy_in),
      .o_Result(res), .o_Busy(o_busy), .o_JumpBranchAddr(jba), .o_PCPlus4(pc4)
   );

   iter_alu #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .i_PC(pc64), .i_Op_5(op64), .i_Operand1(a64), .i_Operand2(b64),
      .i_Valid(vld64), .o_Ready(o_rdy64), .i_Flush(1'b0), .o_Valid(o_vld64), .i_Ready(rdy64),
      .o_Result(res64), .o_Busy(o_busy64), .o_JumpBranchAddr(jba64), .o_PCPlus4(pc464)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one op with i_Ready high, scramble operands while it runs, check result and latency
   task automatic run(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp, input int exp_lat);
      int lat;
      @(negedge clk);
      op = o; a = x; b = y; vld = 1'b1; rdy_in = 1'b1;
      chk({tag, "_rdy"}, o_rdy, 1);
      @(negedge clk);
      vld = 1'b0; a = $urandom; b = $urandom;
      lat = 1;
      while (!o_vld && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk(tag, res, exp);
      chk({tag, "_lat"}, lat, exp_lat);
   endtask

   task automatic run64(input string tag, input logic [4:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp);
      int lat;
      @(negedge clk);
      op64 = o; a64 = x; b64 = y; vld64 = 1'b1; rdy64 = 1'b1;
      @(negedge clk);
      vld64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      lat = 1;
      while (!o_vld64 && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      chk(tag, res64, exp);
      chk({tag, "_lat"}, lat, 65);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, seen;
      logic [127:0]        pu;
      logic signed [127:0] ps;
      logic [63:0]         x64, y64;

      rst_n = 1'b0; pc = 32'h1000; op = OP_ADD; a = '0; b = '0; vld = 1'b0; rdy_in = 1'b1; flush = 1'b0;
      pc64 = '0; op64 = OP_ADD; a64 = '0; b64 = '0; vld64 = 1'b0; rdy64 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", o_vld, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_rdy, 1);
      chk("rst_result", res, 0);
      rst_n = 1'b1;

      // Combinational address outputs wrap modulo 2^32
      @(negedge clk);
      pc = 32'hFFFF_FFFE; a = 32'hFFFF_FFF0; b = 32'h20;
      #1;
      chk("pc_plus4", pc4, 32'h2);
      chk("jump_addr", jba, 32'h10);
      pc = 32'h1000;

      run("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
      run("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
      run("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
      run("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
      run("and", OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1);
      run("or", OP_OR, 32'hF0F0, 32'hFF00, 32'hFFF0, 1);
      run("xor", OP_XOR, 32'hF0F0, 32'hFF00, 32'h0FF0, 1);
      run("sll", OP_SLL, 32'h1, 32'd31, 32'h8000_0000, 1);
      run("srl", OP_SRL, 32'h8000_0000, 32'd31, 32'h1, 1);
      run("sra_mask", OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
      run("lui", OP_LUI, 32'h1234, 32'hABCD_E000, 32'hABCD_E000, 1);
      run("pc4", OP_PC4, 32'h0, 32'h0, 32'h1004, 1);
      run("reserved", OP_RSVD, 32'h55, 32'h66, 32'h0, 1);

      run("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33);
      run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run("rem_posdvd", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'h1, 33);
      run("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
      run("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
      run("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run("remu_zero", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
      run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

      // Backpressure: result held while i_Ready is low, then back-to-back accept
      @(negedge clk);
      op = OP_ADD; a = 32'd1; b = 32'd2; vld = 1'b1; rdy_in = 1'b0;
      @(negedge clk);
      vld = 1'b0;
      chk("bp_valid", o_vld, 1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            op = OP_SUB; a = 32'd9; b = 32'd9; vld = 1'b1;
         end
         @(negedge clk);
         chk("bp_hold_valid", o_vld, 1);
         chk("bp_hold_result", res, 32'd3);
         chk("bp_hold_ready", o_rdy, 0);
      end
      op = OP_ADD; a = 32'd10; b = 32'd20; vld = 1'b1; rdy_in = 1'b1;
      #1;
      chk("bp_release_ready", o_rdy, 1);
      @(negedge clk);
      vld = 1'b0;
      chk("bp_b2b_valid", o_vld, 1);
      chk("bp_b2b_result", res, 32'd30);

      // Flush during a DIVU
      @(negedge clk);
      op = OP_DIVU; a = 32'd1000; b = 32'd3; vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      lat = 1;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("flush_busy_before", o_busy, 1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", o_busy, 0);
      chk("flush_valid", o_vld, 0);
      chk("flush_ready", o_rdy, 1);
      chk("flush_result_kept", res, 32'd30);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_vld) seen++;
      end
      chk("flush_no_valid", seen, 0);

      // Asynchronous reset during a MUL
      @(negedge clk);
      op = OP_MUL; a = 32'd5; b = 32'd6; vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_result", res, 0);
      chk("arst_valid", o_vld, 0);
      chk("arst_busy", o_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst_ready", o_rdy, 1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_vld) seen++;
      end
      chk("arst_no_stale", seen, 0);
      run("post_rst_add", OP_ADD, 32'd2, 32'd2, 32'd4, 1);

      // 64-bit multiply against a 128-bit model
      x64 = 64'h8000_0000_0000_0000; y64 = 64'h8000_0000_0000_0000;
      ps = $signed({{64{x64[63]}}, x64}) * $signed({{64{y64[63]}}, y64});
      run64("mulh64", OP_MULH, x64, y64, ps[127:64]);
      x64 = 64'hFFFF_FFFF_FFFF_FFFF; y64 = 64'hFFFF_FFFF_FFFF_FFFF;
      pu = {64'h0, x64} * {64'h0, y64};
      run64("mulhu64", OP_MULHU, x64, y64, pu[127:64]);
      x64 = 64'hFFFF_FFFF_FFFF_FFFB; y64 = 64'h8000_0000_0000_0003;
      ps = $signed({{64{x64[63]}}, x64}) * $signed({64'h0, y64});
      run64("mulhsu64", OP_MULHSU, x64, y64, ps[127:64]);
      x64 = 64'h1234_5678_9ABC_DEF0; y64 = 64'hFFFF_FFFF_FFFF_FFFD;
      ps = $signed({{64{x64[63]}}, x64}) * $signed({{64{y64[63]}}, y64});
      run64("mul64", OP_MUL, x64, y64, ps[63:0]);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
